// File: rtl/bcd2binary.sv
// Four-digit BCD to 14-bit binary converter.
// Reverse double-dabble, one shift step per clock.
module bcd2binary (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  bcd3,
  input  logic [3:0]  bcd2,
  input  logic [3:0]  bcd1,
  input  logic [3:0]  bcd0,
  output logic [13:0] bin,
  output logic        ready,
  output logic        done_tick,
  output logic        err,
  output logic [3:0]  count,
  output logic [1:0]  state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OP   = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_q;
  state_t      state_d;
  logic [15:0] bcd_work;
  logic [15:0] bcd_next;
  logic [13:0] bin_work;
  logic [13:0] bin_next;
  logic [29:0] shifted;
  logic        bad_digit;
  logic        last_step;

  assign bad_digit = (bcd3 > 4'd9) | (bcd2 > 4'd9) |
                     (bcd1 > 4'd9) | (bcd0 > 4'd9);
  assign last_step = (count == 4'd1);

  // One reverse double-dabble step: shift right, then correct digits >= 8
  always_comb begin
    shifted  = {bcd_work, bin_work} >> 1;
    bin_next = shifted[13:0];
    bcd_next = shifted[29:14];
    for (int i = 0; i < 4; i++) begin
      if (shifted[14 + 4*i +: 4] >= 4'd8)
        bcd_next[4*i +: 4] = shifted[14 + 4*i +: 4] - 4'd3;
    end
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; the unused encoding falls back to IDLE
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (start) state_d = bad_digit ? DONE : OP;
      end
      OP: begin
        if (last_step) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Working registers, iteration counter and posted result
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bcd_work <= '0;
      bin_work <= '0;
      count    <= '0;
      bin      <= '0;
      err      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            if (bad_digit) begin
              bin <= '0;
              err <= 1'b1;
            end else begin
              bcd_work <= {bcd3, bcd2, bcd1, bcd0};
              bin_work <= '0;
              count    <= 4'd14;
            end
          end
        end
        OP: begin
          bcd_work <= bcd_next;
          bin_work <= bin_next;
          count    <= count - 4'd1;
          if (last_step) begin
            bin <= bin_next;
            err <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign ready     = (state_q == IDLE);
  assign done_tick = (state_q == DONE);
  assign state     = state_q;

endmodule

// File: tb/tb_bcd2binary.sv
// Self-checking bench for bcd2binary.
// Randomized digits checked against decimal arithmetic.
module tb_bcd2binary;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [3:0]  bcd3, bcd2, bcd1, bcd0;
  logic [13:0] bin;
  logic        ready, done_tick, err;
  logic [3:0]  count;
  logic [1:0]  state;

  int checks = 0;
  int errors = 0;

  bcd2binary dut (
    .clk(clk), .reset(reset), .start(start),
    .bcd3(bcd3), .bcd2(bcd2), .bcd1(bcd1), .bcd0(bcd0),
    .bin(bin), .ready(ready), .done_tick(done_tick),
    .err(err), .count(count), .state(state)
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  function automatic int ref_value(input logic [15:0] d);
    return 1000 * int'(d[15:12]) + 100 * int'(d[11:8]) +
           10 * int'(d[7:4]) + int'(d[3:0]);
  endfunction

  function automatic logic [15:0] rand_valid();
    logic [15:0] d;
    for (int i = 0; i < 4; i++)
      d[4*i +: 4] = 4'($urandom_range(0, 9));
    return d;
  endfunction

  task automatic set_digits(input logic [15:0] d);
    {bcd3, bcd2, bcd1, bcd0} = d;
  endtask

  task automatic wait_ready();
    int g = 0;
    while (!ready && g < 40) begin
      @(negedge clk);
      g++;
    end
  endtask

  task automatic convert(input logic [15:0] d, output int lat,
                         output logic [13:0] b, output logic e);
    wait_ready();
    set_digits(d);
    start = 1'b1;
    lat = 0;
    do begin
      @(negedge clk);
      start = 1'b0;
      lat++;
    end while (!done_tick && lat < 40);
    b = bin;
    e = err;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    start = 1'b0;
    set_digits(16'h0000);
    repeat (2) @(negedge clk);
    checks++;
    if (state !== 2'd0) begin
      errors++; $display("FAIL reset_state got=%0d want=0", state);
    end
    checks++;
    if (bin !== 14'd0 || err !== 1'b0) begin
      errors++; $display("FAIL reset_bin_err got=%0d/%0b want=0/0", bin, err);
    end
    checks++;
    if (count !== 4'd0 || ready !== 1'b1 || done_tick !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags got count=%0d ready=%0b done=%0b want 0/1/0",
               count, ready, done_tick);
    end
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_hold();
    int lat;
    logic [13:0] b;
    logic e;
    int bad;
    convert(16'h0000, lat, b, e);
    checks++;
    if (b !== 14'd0 || e !== 1'b0 || lat != 15) begin
      errors++; $display("FAIL zero_conv got=%0d err=%0b lat=%0d want 0/0/15", b, e, lat);
    end
    wait_ready();
    set_digits(16'h1234);
    start = 1'b1;
    lat = 0;
    bad = 0;
    do begin
      @(negedge clk);
      start = 1'b0;
      lat++;
      if (lat == 1) begin
        checks++;
        if (count !== 4'd14 || state !== 2'd1 || ready !== 1'b0) begin
          errors++;
          $display("FAIL op_entry got count=%0d state=%0d ready=%0b want 14/1/0",
                   count, state, ready);
        end
      end
      if (!done_tick && bin !== 14'd0) bad++;
    end while (!done_tick && lat < 40);
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL bin_hold got %0d changed cycles want 0", bad);
    end
    checks++;
    if (bin !== 14'd1234 || lat != 15 || count !== 4'd0) begin
      errors++;
      $display("FAIL conv_1234 got=%0d lat=%0d count=%0d want 1234/15/0",
               bin, lat, count);
    end
    @(negedge clk);
    checks++;
    if (ready !== 1'b1 || done_tick !== 1'b0 || bin !== 14'd1234) begin
      errors++;
      $display("FAIL done_one_cycle got ready=%0b done=%0b bin=%0d want 1/0/1234",
               ready, done_tick, bin);
    end
  endtask

  task automatic test_invalid();
    int lat;
    logic [13:0] b;
    logic e;
    logic [15:0] d;
    int pos;
    convert(16'h1A00, lat, b, e);
    checks++;
    if (b !== 14'd0 || e !== 1'b1 || lat != 1) begin
      errors++; $display("FAIL invalid_1A00 got=%0d err=%0b lat=%0d want 0/1/1", b, e, lat);
    end
    convert(16'h0042, lat, b, e);
    checks++;
    if (b !== 14'd42 || e !== 1'b0 || lat != 15) begin
      errors++; $display("FAIL conv_42 got=%0d err=%0b lat=%0d want 42/0/15", b, e, lat);
    end
    for (int k = 0; k < 20; k++) begin
      d = rand_valid();
      convert(d, lat, b, e);
      d = 16'($urandom);
      pos = $urandom_range(0, 3);
      d[4*pos +: 4] = 4'($urandom_range(10, 15));
      convert(d, lat, b, e);
      checks++;
      if (b !== 14'd0 || e !== 1'b1 || lat != 1) begin
        errors++;
        $display("FAIL invalid_rand d=%h got=%0d err=%0b lat=%0d want 0/1/1",
                 d, b, e, lat);
      end
    end
  endtask

  task automatic test_back_to_back();
    int cyc = 0;
    int last = -1;
    int n = 0;
    wait_ready();
    set_digits(16'h0500);
    start = 1'b1;
    while (n < 4 && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (state == 2'd1) set_digits(16'($urandom));
      if (done_tick) begin
        n++;
        checks++;
        if (bin !== 14'd500 || err !== 1'b0) begin
          errors++; $display("FAIL b2b_value got=%0d err=%0b want 500/0", bin, err);
        end
        if (last >= 0) begin
          checks++;
          if (cyc - last != 16) begin
            errors++; $display("FAIL b2b_period got=%0d want 16", cyc - last);
          end
        end
        last = cyc;
        set_digits(16'h0500);
      end
    end
    start = 1'b0;
    checks++;
    if (n != 4) begin
      errors++; $display("FAIL b2b_count got=%0d want 4", n);
    end
  endtask

  task automatic test_reset_mid_op();
    int g = 0;
    int lat;
    logic [13:0] b;
    logic e;
    wait_ready();
    set_digits(16'h1111);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (count !== 4'd7 && g < 20) begin
      @(negedge clk);
      g++;
    end
    checks++;
    if (count !== 4'd7 || done_tick !== 1'b0) begin
      errors++; $display("FAIL reach_count7 got=%0d done=%0b want 7/0", count, done_tick);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (state !== 2'd0 || bin !== 14'd0 || count !== 4'd0 ||
        ready !== 1'b1 || done_tick !== 1'b0) begin
      errors++;
      $display("FAIL async_reset got state=%0d bin=%0d count=%0d ready=%0b done=%0b",
               state, bin, count, ready, done_tick);
    end
    set_digits(16'h0007);
    start = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (state !== 2'd0 || done_tick !== 1'b0) begin
      errors++; $display("FAIL held_reset got state=%0d done=%0b want 0/0", state, done_tick);
    end
    start = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    convert(16'h0007, lat, b, e);
    checks++;
    if (b !== 14'd7 || e !== 1'b0 || lat != 15) begin
      errors++; $display("FAIL post_reset_7 got=%0d err=%0b lat=%0d want 7/0/15", b, e, lat);
    end
  endtask

  task automatic test_random();
    int lat;
    logic [13:0] b;
    logic e;
    logic [15:0] d;
    logic [15:0] edges [8] = '{16'h0000, 16'h9999, 16'h0001, 16'h9000,
                               16'h0999, 16'h1000, 16'h0009, 16'h5555};
    for (int k = 0; k < 308; k++) begin
      d = (k < 8) ? edges[k] : rand_valid();
      convert(d, lat, b, e);
      checks++;
      if (int'(b) != ref_value(d) || e !== 1'b0) begin
        errors++;
        $display("FAIL conv_value d=%h got=%0d err=%0b want %0d/0",
                 d, b, e, ref_value(d));
      end
      checks++;
      if (lat != 15) begin
        errors++; $display("FAIL conv_latency d=%h got=%0d want 15", d, lat);
      end
    end
  endtask

  initial begin
    start = 1'b0;
    reset = 1'b1;
    set_digits(16'h0000);
    test_reset();
    test_hold();
    test_invalid();
    test_back_to_back();
    test_reset_mid_op();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bcd2binary.md
BCD2BINARY -- requirements
Module: bcd2binary

Interface
REQ-001 SHALL have no parameters; all widths are fixed: 4 BCD digits in, 14-bit binary out.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  reset, asynchronous and active-low; asserted when 0.
REQ-004 start  input  1  conversion request, sampled only in IDLE.
REQ-005 bcd3, bcd2, bcd1, bcd0  input  4 each  BCD digits; bcd3 is thousands, bcd0 is units.
REQ-006 bin  output  14  registered binary result.
REQ-007 ready  output  1  high while in IDLE.
REQ-008 done_tick  output  1  one-cycle pulse when a result (or error) is posted.
REQ-009 err  output  1  high when the last accepted request had a digit >9.
REQ-010 count  output  4  remaining shift iterations, for debug.
REQ-011 state  output  2  state encoding: IDLE=0, OP=1, DONE=2.

Function
REQ-012 SHALL implement a 3-state FSM: IDLE, OP, DONE; encoding 3 is unreachable and SHALL recover to IDLE.
REQ-013 IDLE, start=1, all digits ≤9: on that edge, load working BCD register {bcd3,bcd2,bcd1,bcd0} (16b), clear 14b working binary register, count<=14, go to OP.
REQ-014 IDLE, start=1, any digit >9: on that edge, bin<=0, err<=1, go directly to DONE; no shifting.
REQ-015 Each OP cycle SHALL do one reverse double-dabble step: shift the 30b concatenation {bcd_work, bin_work} right by 1, then subtract 3 from each 4b BCD digit whose post-shift value is ≥8; count decrements by 1.
REQ-016 On the OP edge where count goes 1->0: bin<=final bin_work, err<=0, go to DONE.
REQ-017 Latency: done_tick SHALL be high exactly 15 cycles after the accepting start edge (14 OP cycles plus DONE) for a valid request, and 1 cycle after it for an invalid request.
REQ-018 DONE SHALL last exactly one cycle with done_tick=1, then return to IDLE unconditionally.
REQ-019 start SHALL be ignored in OP and DONE; the inputs are not re-sampled after the load edge, so input changes mid-conversion have no effect.
REQ-020 start held continuously high SHALL start a new conversion on every IDLE cycle; the back-to-back period is 16 cycles.
REQ-021 bin and err SHALL hold their last values from DONE through IDLE and OP until the next DONE.
REQ-022 ready SHALL be combinationally (state==IDLE); done_tick SHALL be combinationally (state==DONE).
REQ-023 count SHALL read 0 in IDLE and DONE.
REQ-024 The result SHALL equal 1000*bcd3 + 100*bcd2 + 10*bcd1 + bcd0; the maximum is 9999, so no overflow is possible.

Reset
REQ-025 reset=0 SHALL immediately force: state=IDLE, bin=0, err=0, count=0, working registers=0, ready=1, done_tick=0.
REQ-026 Reset asserted mid-OP SHALL abort the conversion with no done_tick; bin SHALL read 0 after reset.
REQ-027 After reset deasserts, the first valid start SHALL convert normally with the REQ-017 latency.

Verification
REQ-028 Digits 9,9,9,9 and start pulse -> done_tick 15 cycles later, bin=9999 (0x270F), err=0.
REQ-029 Digits 0,0,0,0 -> bin=0, err=0; then 1,2,3,4 -> bin=1234 (0x4D2); bin holds 0 throughout the second conversion until its DONE.
REQ-030 Digits 1,0xA,0,0 -> done_tick 1 cycle after start, bin=0, err=1; next valid request 0,0,4,2 -> bin=42, err=0.
REQ-031 start held high with digits 0,5,0,0 -> done_tick every 16 cycles, bin=500 each time; digits changed during OP do not alter the in-flight result.
REQ-032 reset=0 pulsed at OP count=7 -> no done_tick, bin=0, state=0; a following start with 0,0,0,7 -> bin=7.
REQ-033 Exhaustive sweep 0..9999 SHALL compare bin against the REQ-024 reference model.
